dsp_ccff_readback: RTL

DSP_CCFF_READBACK -- requirements
Module: dsp_ccff_readback

---
 rtl/dsp_ccff_readback.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dsp_ccff_readback.sv
// Configuration-chain readback: rotates the DSP tile chain once through itself
// and streams the captured bits out as LSB-first bytes over valid/ready.
module dsp_ccff_readback #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 10
) (
  input  logic       prog_clk,
  input  logic       pReset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       ccff_tail,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       acc_q, acc_d;
  logic             held_q, held_d;
  logic [7:0]       hbyte_q, hbyte_d;
  logic             hlast_q, hlast_d;
  logic [7:0]       odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;

  logic [7:0] acc_bit;
  logic       final_bit;
  logic       byte_done;
  logic       accept;
  logic       oreg_free;

  always_comb begin
    acc_bit   = acc_q | (8'(ccff_tail) << bidx_q);
    final_bit = (cnt_q == LAST_CNT);
    byte_done = (bidx_q == 3'd7) || final_bit;
    accept    = ovalid_q & out_ready;
    oreg_free = ~ovalid_q | out_ready;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    acc_d    = acc_q;
    held_d   = held_q;
    hbyte_d  = hbyte_q;
    hlast_d  = hlast_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;

    if (accept) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bidx_d  = '0;
          acc_d   = '0;
          held_d  = 1'b0;
        end
      end
      SHIFT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        bidx_d = bidx_q + 3'd1;
        acc_d  = acc_bit;
        if (byte_done) begin
          acc_d  = '0;
          bidx_d = '0;
          if (oreg_free) begin
            odata_d  = acc_bit;
            ovalid_d = 1'b1;
            olast_d  = final_bit;
            if (final_bit) begin
              state_d = HOLD;
            end
          end else begin
            held_d  = 1'b1;
            hbyte_d = acc_bit;
            hlast_d = final_bit;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Without a held byte, HOLD just waits for the last byte to drain.
        if (held_q) begin
          if (accept) begin
            odata_d  = hbyte_q;
            ovalid_d = 1'b1;
            olast_d  = hlast_q;
            held_d   = 1'b0;
            if (!hlast_q) begin
              state_d = SHIFT;
            end
          end
        end else if (accept && olast_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      bidx_d   = '0;
      acc_d    = '0;
      held_d   = 1'b0;
      hlast_d  = 1'b0;
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bidx_q   <= '0;
      acc_q    <= '0;
      held_q   <= 1'b0;
      hbyte_q  <= '0;
      hlast_q  <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      acc_q    <= acc_d;
      held_q   <= held_d;
      hbyte_q  <= hbyte_d;
      hlast_q  <= hlast_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign ccff_shift_en = (state_q == SHIFT);
  assign ccff_head     = ccff_shift_en & ccff_tail;
  assign out_data      = odata_q;
  assign out_valid     = ovalid_q;
  assign out_last      = olast_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule
